// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// slave is the unit's view; master is the CPU-plus-memory side.
interface load_store_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspError;
    logic [31:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memReadData,
        output reqReady, rspValid, rspData, rspError, memAddr, memRead, memWrite, memWriteData
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memReadData,
        input  reqReady, rspValid, rspData, rspError, memAddr, memRead, memWrite, memWriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed little-endian load/store unit; sub-word stores read-modify-write the word.
// Latency: error 1, load/word store 2, sub-word store 3 cycles; one request in flight at a time.
module load_store_unit (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE_RD, STORE_WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q;
    logic        signed_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] rsp_data_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic [31:0] word_addr;

    assign accept    = bus.reqValid && (state_q == IDLE);
    assign word_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        case (bus.reqSize)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.reqAddr[0];
            2'b10:   req_err = |bus.reqAddr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        byte_v   = bus.memReadData[{addr_q[1:0], 3'b000} +: 8];
        half_v   = addr_q[1] ? bus.memReadData[31:16] : bus.memReadData[15:0];
        load_val = bus.memReadData;
        case (size_q)
            2'b00:   load_val = {{24{signed_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{signed_q & half_v[15]}}, half_v};
            default: load_val = bus.memReadData;
        endcase
    end

    // Only the addressed lane of the previously read word is replaced.
    always_comb begin
        merged = rdata_q;
        case (size_q)
            2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q    <= bus.reqWrite;
                signed_q   <= bus.reqSigned;
                err_q      <= req_err;
                size_q     <= bus.reqSize;
                addr_q     <= bus.reqAddr;
                wdata_q    <= bus.reqWData;
                rsp_data_q <= '0;
            end
            if (state_q == LOAD)     rsp_data_q <= load_val;
            if (state_q == STORE_RD) rdata_q    <= bus.memReadData;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.reqReady     = 1'b0;
        bus.rspValid     = 1'b0;
        bus.rspData      = '0;
        bus.rspError     = 1'b0;
        bus.memRead      = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memAddr      = '0;
        bus.memWriteData = '0;
        case (state_q)
            IDLE: begin
                bus.reqReady = 1'b1;
                if (bus.reqValid) begin
                    if (req_err)                 state_d = RESP;
                    else if (!bus.reqWrite)      state_d = LOAD;
                    else if (bus.reqSize == 2'b10) state_d = STORE_WR;
                    else                         state_d = STORE_RD;
                end
            end
            LOAD, STORE_RD: begin
                bus.memRead = 1'b1;
                bus.memAddr = word_addr;
                state_d     = (state_q == LOAD) ? RESP : STORE_WR;
            end
            STORE_WR: begin
                bus.memWrite     = 1'b1;
                bus.memAddr      = word_addr;
                bus.memWriteData = merged;
                state_d          = RESP;
            end
            RESP: begin
                bus.rspValid = 1'b1;
                bus.rspData  = rsp_data_q;
                bus.rspError = err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // write_q is kept for visibility of the latched request; routing is decided at accept.
    logic unused_write;
    assign unused_write = write_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses, a monitor pops and compares.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] mem [64];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: combinational read, write commits on the falling edge.
    assign bus.memReadData = mem[bus.memAddr[7:2]];
    always @(negedge clk) begin
        if (bus.memRead) rd_cnt <= rd_cnt + 1;
        if (bus.memWrite) begin
            mem[bus.memAddr[7:2]] <= bus.memWriteData;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.memAddr;
            last_wr_data <= bus.memWriteData;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            check("mem_rd_wr_exclusive", 32'(bus.memRead & bus.memWrite), 32'd0);
            if (bus.rspValid) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rspValid at cycle %0d, expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_data", bus.rspData, e.data);
                    check("rsp_error", 32'(bus.rspError), 32'(e.err));
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("rsp_quiet", bus.rspData | 32'(bus.rspError), 32'd0);
            end
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge where reqReady is back.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input int lat,
                         input logic hold);
        int   n;
        int   busy;
        exp_t e;
        bus.reqValid  = 1'b1;
        bus.reqWrite  = wr;
        bus.reqSize   = sz;
        bus.reqSigned = sg;
        bus.reqAddr   = a;
        bus.reqWData  = wd;
        n = 0;
        while (!bus.reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.reqReady) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got reqReady=0 for %0d cycles, expected 1", n);
            bus.reqValid = 1'b0;
            return;
        end
        e.data = exp_d;
        e.err  = exp_e;
        e.cyc  = cyc + lat;
        sb_q.push_back(e);
        @(negedge clk);
        if (!hold) bus.reqValid = 1'b0;
        busy = 0;
        while (!bus.reqReady && busy < 20) begin
            @(negedge clk);
            busy++;
        end
        check("busy_cycles", 32'(busy), 32'(lat));
    endtask

    int rd0;
    int wr0;
    int n;

    initial begin
        bus.reqValid  = 1'b1;
        bus.reqWrite  = 1'b1;
        bus.reqSize   = 2'b10;
        bus.reqSigned = 1'b0;
        bus.reqAddr   = 32'h10;
        bus.reqWData  = 32'hFFFF_FFFF;
        fork
            monitor();
        join_none

        // A request presented while rst is high must be dropped.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.reqValid = 1'b0;
        check("rst_reqReady", 32'(bus.reqReady), 32'd1);
        check("rst_rspValid", 32'(bus.rspValid), 32'd0);
        check("rst_rspData", bus.rspData, 32'd0);
        check("rst_rspError", 32'(bus.rspError), 32'd0);
        check("rst_memRead", 32'(bus.memRead), 32'd0);
        check("rst_memWrite", 32'(bus.memWrite), 32'd0);
        check("rst_memAddr", bus.memAddr, 32'd0);
        check("rst_memWriteData", bus.memWriteData, 32'd0);
        repeat (2) @(negedge clk);
        #1 check("rst_req_ignored_wr", 32'(wr_cnt), 32'd0);
        @(negedge clk);

        // Word store then load.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 2, 1'b0);
        #1;
        check("sw_wr_cnt", 32'(wr_cnt), 32'd1);
        check("sw_wr_addr", last_wr_addr, 32'h10);
        check("sw_wr_data", last_wr_data, 32'h1122_3344);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 2, 1'b0);

        // Sub-word read-modify-write.
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AB, 32'h0, 1'b0, 3, 1'b0);
        #1;
        check("sb_rd_cycles", 32'(rd_cnt - rd0), 32'd1);
        check("sb_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
        check("sb_wr_addr", last_wr_addr, 32'h10);
        check("sb_wr_data", last_wr_data, 32'h11AB_3344);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11AB_3344, 1'b0, 2, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_5566, 32'h0, 1'b0, 3, 1'b0);
        #1 check("sh_wr_data", last_wr_data, 32'h5566_3344);

        // Extension cases on 0x80F07F85.
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F0_7F85, 32'h0, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hFFFF_FF85, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0000_0085, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_80F0, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_80F0, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_7F85, 1'b0, 2, 1'b0);
        issue(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h80F0_7F85, 1'b0, 2, 1'b0);

        // Misaligned and reserved-size requests never touch memory.
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b0);
        #1;
        check("err_no_memRead", 32'(rd_cnt - rd0), 32'd0);
        check("err_no_memWrite", 32'(wr_cnt - wr0), 32'd0);

        // reqValid held high across a back-to-back sequence.
        issue(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h24, 32'h0, 32'h0000_000D, 1'b0, 2, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h27, 32'h0000_0011, 32'h0, 1'b0, 3, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h26, 32'h0, 32'h0000_11FE, 1'b0, 2, 1'b0);

        // Reset during STORE_RD of a half store aborts it.
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b0);
        #1 wr0 = wr_cnt;
        bus.reqValid  = 1'b1;
        bus.reqWrite  = 1'b1;
        bus.reqSize   = 2'b01;
        bus.reqSigned = 1'b0;
        bus.reqAddr   = 32'h30;
        bus.reqWData  = 32'h0000_1234;
        @(negedge clk);
        check("abort_in_store_rd", 32'(bus.memRead), 32'd1);
        bus.reqValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_reqReady", 32'(bus.reqReady), 32'd1);
        check("abort_outputs_zero",
              bus.rspData | bus.memAddr | bus.memWriteData |
              32'({bus.rspValid, bus.rspError, bus.memRead, bus.memWrite}), 32'd0);
        repeat (3) @(negedge clk);
        #1 check("abort_no_memWrite", 32'(wr_cnt - wr0), 32'd0);
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; data and address widths are fixed at 32 bits, and memory is byte-addressed little-endian.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- reqValid  in  1  CPU access request
- reqReady  out  1  block can accept a request
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word, 11 reserved
- reqSigned  in  1  sign-extend a byte/half load
- reqAddr  in  32  byte address
- reqWData  in  32  store data; the low byte/half is used for sub-word stores
- rspValid  out  1  one-cycle completion pulse
- rspData  out  32  load result; 0 for stores and errors
- rspError  out  1  misaligned or reserved-size request; valid with rspValid
- memAddr  out  32  word-aligned address to data memory, {addr[31:2],2'b00}
- memRead  out  1  memory read enable; memory returns data combinationally
- memWrite  out  1  memory write enable; memory commits on the falling clk edge of the same cycle
- memWriteData  out  32  full word to write
- memReadData  in  32  word returned by memory

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, STORE_RD, STORE_WR and RESP.
REQ-004 reqReady SHALL be 1 only in IDLE; a request is accepted on a rising edge with reqValid=1 and reqReady=1, and all request fields are latched then.
REQ-005 In IDLE, the block SHALL flag these requests as errors:
- reqSize=11
- half access with reqAddr[0]=1
- word access with reqAddr[1:0]!=00
An error request SHALL go to RESP with rspError=1, and memRead and memWrite SHALL stay 0.
REQ-006 A legal load SHALL go to LOAD; a legal word store SHALL go to STORE_WR; a legal byte/half store SHALL go to STORE_RD.
REQ-007 LOAD and STORE_RD SHALL each last exactly one cycle, with memRead=1, memWrite=0 and memAddr set to the latched word address; memReadData is captured at the closing rising edge.
REQ-008 STORE_WR SHALL last exactly one cycle, with memWrite=1, memRead=0 and memWriteData set as follows:
- word store: the latched reqWData
- sub-word store: the word captured in STORE_RD with only the target lane replaced
  - byte lane = addr[1:0], i.e. bits [8*k+7:8*k]
  - half lane = addr[1], i.e. bits [15:0] or [31:16]
REQ-009 Load extraction SHALL select the byte lane by addr[1:0] and the half lane by addr[1], then:
- zero-extend when reqSigned=0
- sign-extend from the lane MSB when reqSigned=1
- word loads ignore reqSigned
REQ-010 RESP SHALL last exactly one cycle, with rspValid=1, then return to IDLE; rspData and rspError SHALL be 0 whenever rspValid=0.
REQ-011 Latency from the accept edge to the cycle with rspValid=1 SHALL be:
- error: 1 cycle
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
REQ-012 memRead and memWrite SHALL never both be 1, and both SHALL be 0 in IDLE and RESP.
REQ-013 memAddr SHALL be driven from registered state only, never combinationally from req* inputs; memWriteData SHALL be 0 outside STORE_WR.
REQ-014 A new request SHALL NOT be accepted in the RESP cycle; back-to-back throughput is therefore one request per latency+1 cycles.

Reset
REQ-015 When rst=1 at a rising edge, the state SHALL become IDLE and all latched fields SHALL be cleared.
REQ-016 In the cycle after reset:
- reqReady=1
- rspValid=0, rspData=0, rspError=0
- memRead=0, memWrite=0
- memAddr=0, memWriteData=0
REQ-017 Reset asserted in any state, including mid-access (LOAD, STORE_RD or STORE_WR), SHALL abort the access with no rspValid pulse and no further memWrite cycle.
REQ-018 A request presented in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Word store then load: sw 0x11223344 to 0x10, then lw 0x10 -> memWrite=1 for one cycle with memAddr=0x10; rspData=0x11223344, rspError=0.
- Sub-word store RMW: mem[0x10]=0x11223344, sb 0xAB to 0x12 -> one read cycle, then one write cycle with memWriteData=0x11AB3344; rspValid at accept+3.
- Sign extension: mem[0x20]=0x80F07F85 ->
  - lb 0x20 gives 0xFFFFFF85
  - lbu 0x20 gives 0x00000085
  - lh 0x22 gives 0xFFFF80F0
  - lhu 0x22 gives 0x000080F0
- Errors: lw 0x21, sh 0x13 or reqSize=11 -> rspError=1 at accept+1, rspData=0, no memRead/memWrite pulse.
- Handshake: reqValid held high continuously -> reqReady=0 from accept through RESP; requests accepted only in IDLE; no request lost or duplicated.
- Reset mid-store: rst=1 during STORE_RD of an sh -> next cycle IDLE with all outputs 0; memWrite never asserted, so memory is unchanged.
